// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per clock
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              sa, sb;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   rem;
  logic [CNT_W-1:0]  cnt;

  logic              a_signed, b_signed, sa_in, sb_in, div0, ovf;
  logic [XLEN-1:0]   ma, mb, special_res;
  logic [XLEN:0]     mul_sum, rem_sh, rem_sub;
  logic              ge;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   q_s, r_s, fix_res;

  // Operand conditioning at launch: signedness, magnitudes and the divide corner cases
  always_comb begin
    a_signed    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_signed    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    sa_in       = a_signed & rs1[XLEN-1];
    sb_in       = b_signed & rs2[XLEN-1];
    ma          = sa_in ? -rs1 : rs1;
    mb          = sb_in ? -rs2 : rs2;
    div0        = op[2] && (rs2 == '0);
    ovf         = op[2] && !op[0] && (rs1 == MIN_NEG) && (rs2 == '1);
    special_res = div0 ? (op[1] ? rs1 : '1) : (op[1] ? '0 : MIN_NEG);
  end

  // One iteration step; the low product half doubles as multiplier / quotient shift register
  always_comb begin
    mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_mag} : '0);
    rem_sh  = {rem, prod[XLEN-1]};
    rem_sub = rem_sh - {1'b0, b_mag};
    ge      = rem[XLEN-1] | ~rem_sub[XLEN];
  end

  always_comb begin
    prod_s  = (sa ^ sb) ? -prod : prod;
    q_s     = (sa ^ sb) ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    r_s     = sa ? -rem : rem;
    fix_res = prod_s[XLEN-1:0];
    case (op_q)
      3'd1, 3'd2, 3'd3: fix_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_res = q_s;
      3'd6, 3'd7:       fix_res = r_s;
      default:          fix_res = prod_s[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      prod   <= '0;
      rem    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            a_mag <= ma;
            b_mag <= mb;
            sa    <= sa_in;
            sb    <= sb_in;
            prod  <= {{XLEN{1'b0}}, (op[2] ? ma : mb)};
            rem   <= '0;
            cnt   <= '0;
            if (div0 || ovf) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (op_q[2]) begin
            rem  <= ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
            prod <= {prod[2*XLEN-1:XLEN], prod[XLEN-2:0], ge};
          end else begin
            prod <= {mul_sum, prod[XLEN-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    int ia, ib;
    ia = a;
    ib = b;
    p = 64'd0;
    r = 32'd0;
    case (o)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = ia / ib;
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = ia % ib;
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    exp_q.push_back(model(o, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int exp_busy);
    int n;
    int bc;
    bit seen;
    logic [31:0] exp;
    n = 1; bc = 0; seen = 1'b0;
    while (n <= 200) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      if (busy) bc++;
      @(posedge clk);
      n++;
    end
    exp = exp_q.pop_front();
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s timeout: no done within 200 cycles", name);
    end else begin
      if (result !== exp) begin
        fails++;
        $display("FAIL %s result: got %h expected %h", name, result, exp);
      end
      tests++;
      if (n !== exp_lat) begin
        fails++;
        $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
      end
      tests++;
      if (bc !== exp_busy) begin
        fails++;
        $display("FAIL %s busy cycles: got %0d expected %0d", name, bc, exp_busy);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL %s done width: got done=%b expected 0 next cycle", name, done);
      end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit sp;
    sp = is_special(o, a, b);
    issue(o, a, b);
    wait_done(name, sp ? 1 : 34, sp ? 0 : 33);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy, done, result} !== 34'd0) begin
      fails++;
      $display("FAIL reset: got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_mul;
    run_op("mul_7x6", 3'd0, 32'd7, 32'd6);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_neg", 3'd2, 32'hFFFF_FFFF, 32'd2);
  endtask

  task automatic test_div;
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
  endtask

  task automatic test_special;
    run_op("divu_by0", 3'd5, 32'd5, 32'd0);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
      if (i % 3 == 1) b = 32'($urandom_range(1, 300));
      run_op($sformatf("rand%0d_op%0d", i, o), o, a, b);
    end
  endtask

  task automatic test_ignore_start;
    int n;
    bit seen;
    logic [31:0] exp;
    issue(3'd0, 32'd3, 32'd3);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; op = 3'd4; rs1 = 32'd100; rs2 = 32'd100;
    @(posedge clk);
    #1 start = 1'b0; rs1 = 32'd55; rs2 = 32'd77;
    n = 0; seen = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      n++;
    end
    exp = exp_q.pop_front();
    tests++;
    if (!seen || result !== exp) begin
      fails++;
      $display("FAIL ignore_start result: got %h seen=%b expected %h", result, seen, exp);
    end
    start = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL start_in_done cycle%0d: got busy=%b done=%b expected 0 0", k, busy, done);
      end
    end
  endtask

  task automatic test_abort;
    @(posedge clk);
    #1 start = 1'b1; op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, result} !== 34'd0) begin
      fails++;
      $display("FAIL abort: got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op("mul_after_abort", 3'd0, 32'd2, 32'd2);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_ignore_start();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit for the multi-cycle core.
- Sits beside the single-cycle ALU. Its registered result feeds the same result path into the ALU output register.
- The control FSM launches it with a start pulse, stalls on busy, and captures result when done pulses.
- Shift-add multiply and restoring divide, one bit per clock.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported and verified.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1  input  32  operand A (multiplicand/dividend).
- rs2  input  32  operand B (multiplier/divisor).
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result valid in that cycle.
- result  output  32  registered result; holds its value until the next done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches op, rs1 and rs2 internally.
  - Later operand changes have no effect.
- Sign handling, done at latch time:
  - signed operands: MULH both, MULHSU rs1 only, DIV/REM both.
  - Magnitudes are taken; result sign is recorded.
  - MUL low word is sign-agnostic and is computed unsigned.
- Special divide cases, detected in IDLE: IDLE -> DONE directly (done 1 cycle after start).
  - divisor=0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
  - DIV with rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Normal case: IDLE -> CALC; 32 CALC cycles, counter counts 0..31.
  - Multiply: 64-bit product accumulated, one multiplier bit per cycle.
  - Divide: restoring; shift partial remainder left, trial-subtract divisor, set quotient bit.
- After counter=31: CALC -> FIX (1 cycle).
  - Apply negation if the recorded sign requires it.
  - Product sign = sA xor sB. Quotient sign = sA xor sB. Remainder sign = sA.
  - Select word: low product for MUL, high product for MULH*, quotient for DIV*, remainder for REM*.
  - Register the selected word into result.
- FIX -> DONE; done=1 for exactly one cycle; DONE -> IDLE.
- Latency:
  - start sampled at edge 0; done is high in the cycle after edge 34 (34 cycles) for normal ops.
  - Special cases: done high in the cycle after edge 1.
- busy=1 in CALC and FIX; busy=0 in IDLE and DONE.
- start while not IDLE (including the DONE cycle) is ignored, not queued.
- result changes only on the transition into DONE; otherwise it is stable.
- rst_n low mid-operation aborts immediately to reset values; no done is produced.
- Width rules:
  - Internal product is 64-bit.
  - Divider remainder datapath is 33-bit to hold the borrow.
  - Negation is two's complement on the full width before word select.

Test Plan:
- MUL rs1=7, rs2=6 -> done after 34 cycles, result=42; busy high 33 cycles; done high exactly 1 cycle.
- MULH rs1=0x80000000, rs2=0x80000000 -> 0x40000000. MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=-7, rs2=2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIVU rs1=100, rs2=7 -> 14. REMU same operands -> 2.
- DIVU rs1=5, rs2=0 -> 0xFFFFFFFF with done 1 cycle after start. REM rs1=5, rs2=0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- Start MUL 3*3. Pulse start with different operands during CALC -> ignored, result=9. Change rs1 mid-op -> no effect.
- Start DIV, assert rst_n=0 at iteration 10 -> busy=0, done=0, result=0 at once. Release reset, run MUL 2*2 -> result=4 normally.
